kyber_decompress_stream: RTL
============================

Name: kyber_decompress_stream

Overview:
Streaming, multi-lane successor to the combinational Kyber decompress unit.
- Each lane computes Decompress_q(x,d) = (x*3329 + 2^(d-1)) >> d for d in 1..11.
- Coefficients arrive as a valid/ready stream of LANES per beat and pass through a 2-stage stall-able pipeline.
- A polynomial counter tags the final beat of each 256-coefficient polynomial.
- Sits between the ciphertext unpacker and the NTT/poly arithmetic path.

Parameters:
LANES, 4, coefficients per beat; legal values are powers of two from 1 to 16 (256 % LANES == 0).
Q, 3329, modulus; fixed for Kyber and exposed only for verification.
NCOEFF, 256, coefficients per polynomial.

Ports:
i_clk  input  1  clock, rising edge
i_rstn  input  1  asynchronous active-low reset
i_valid  input  1  input beat valid
o_ready  output  1  block can accept an input beat
i_coeff  input  11*LANES  compressed coefficients; lane k at bits [11k+10:11k]; lane 0 = lowest index
i_d  input  4  compression bit-width for this beat
o_valid  output  1  output beat valid
i_ready  input  1  downstream accepts output beat
o_coeff  output  12*LANES  decompressed coefficients; lane k at bits [12k+11:12k]
o_last  output  1  asserted with the beat carrying coefficient NCOEFF-1 of a polynomial
o_range_err  output  1  sticky range-error flag (see Optional Feature)

Behaviour:
- Reset (async assert, sync deassert by the driver): o_valid=0, o_coeff=0, o_last=0, o_range_err=0, beat counter=0, all pipeline valids=0. o_ready is 1 one cycle after reset release.
- Handshake:
  - An input transfer occurs when i_valid && o_ready.
  - An output transfer occurs when o_valid && i_ready.
  - While o_valid && !i_ready, o_coeff and o_last hold stable.
- Pipeline:
  - Global enable en = !o_valid | i_ready. o_ready = en.
  - Stage 1 registers the masked x, the products x*Q (23 bits per lane), d, and the last-tag.
  - Stage 2 registers (prod + rnd) >> d, truncated to 12 bits.
  - Latency is 2 cycles from accepted input to o_valid, with full throughput of 1 beat/cycle when i_ready is held high.
  - Bubbles propagate: a stage valid is loaded with the upstream valid whenever en=1.
- Arithmetic:
  - x is masked to its low d bits.
  - rnd = 1 << (d-1).
  - The result is always <= Q-1, because x < 2^d.
  - For d = 0 or d > 11, every lane outputs 0 with no error raised, and the beat still counts toward the polynomial.
- i_d is sampled per beat and may change between beats; it is carried with its beat through the pipeline.
- Polynomial counter:
  - Counts accepted input beats modulo NCOEFF/LANES.
  - A beat is tagged last when counter == NCOEFF/LANES-1 at acceptance; the counter then wraps to 0.
  - The tag travels with its beat, and o_last is qualified by o_valid.
- Simultaneous input accept and output drain in the same cycle is legal and must not drop or duplicate beats.
- Asserting reset mid-polynomial discards in-flight beats and restarts the counter at 0.

Optional Feature:
Macro DECOMPRESS_RANGE_CHK_EN.
- Defined:
  - On every accepted beat, if any lane has i_coeff bits at or above bit position d set (d in 1..11), o_range_err sets on the next cycle.
  - If d = 0 or d > 11, o_range_err also sets.
  - It stays 1 until reset. Data path behaviour is unchanged (masking still applies).
- Not defined: o_range_err is tied to 0 and no check logic is synthesised.

Test Plan:
1. LANES=4, d=1, lanes x={1,0,1,0}, i_ready=1 -> two cycles later o_valid=1, o_coeff lanes {1665,0,1665,0}.
2. d=10 with x=1023 -> 3326; d=11 with x=2047 -> 3327; d=4 with x=15 -> 3121; d=5 with x=16 -> 1665. Run as back-to-back beats with a different d per beat; each output matches its own d.
3. 64 consecutive beats (LANES=4) -> o_last=1 only on output beat 64; beat 65 starts a new polynomial with o_last=0. Check across 10 polynomials against a golden vector file.
4. Hold i_ready=0 for 5 cycles during a stream -> o_ready drops to 0 once the pipeline is full; o_coeff is held stable; after i_ready=1 all beats emerge in order with none lost.
5. Pulse i_rstn low after 30 beats -> o_valid=0 immediately; the next polynomial's o_last lands on its 64th beat.
6. With DECOMPRESS_RANGE_CHK_EN defined: d=4, x=0x010 -> o_coeff=0 and o_range_err=1, sticky through later clean beats. Without the macro the same stimulus gives o_range_err=0.

Source files
------------

// File: rtl/kyber_decompress_stream_if.sv
// Stream bundle for kyber_decompress_stream: compressed beats in, decompressed beats out.
// The slave modport is the decompressor's view; the master modport is the driver/sink side.
interface kyber_decompress_stream_if #(
    parameter int LANES = 4
);
    logic                   i_valid;
    logic                   o_ready;
    logic [11*LANES-1:0]    i_coeff;
    logic [3:0]             i_d;
    logic                   o_valid;
    logic                   i_ready;
    logic [12*LANES-1:0]    o_coeff;
    logic                   o_last;
    logic                   o_range_err;

    modport master (
        output i_valid, i_coeff, i_d, i_ready,
        input  o_ready, o_valid, o_coeff, o_last, o_range_err
    );

    modport slave (
        input  i_valid, i_coeff, i_d, i_ready,
        output o_ready, o_valid, o_coeff, o_last, o_range_err
    );
endinterface

// File: rtl/kyber_decompress_stream.sv
// Streaming multi-lane Kyber decompress: y = (x*Q + 2^(d-1)) >> d, 2-stage stall-able pipeline.
// Optional sticky range check on input coefficients is built when DECOMPRESS_RANGE_CHK_EN is defined.
module kyber_decompress_lane #(
    parameter int Q = 3329
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        ld1,
    input  logic        ld2,
    input  logic [3:0]  d_in,
    input  logic [3:0]  d_s1,
    input  logic [10:0] x_in,
    output logic [11:0] y_out
`ifdef DECOMPRESS_RANGE_CHK_EN
    ,
    output logic        hi_err
`endif
);
    logic        d_ok;
    logic        s1_ok;
    logic [10:0] mask;
    logic [10:0] x_m;
    logic [22:0] prod_d, prod_q;
    logic [22:0] rnd;
    logic [11:0] y_d, y_q;

    always_comb begin
        d_ok  = (d_in >= 4'd1) && (d_in <= 4'd11);
        mask  = '0;
        for (int b = 0; b < 11; b++) mask[b] = d_ok && (b < int'(d_in));
        x_m   = x_in & mask;
        prod_d = ld1 ? 23'(x_m) * 23'(Q) : prod_q;

        // An out-of-range d already zeroed the product; dropping rnd keeps the result at 0.
        s1_ok = (d_s1 >= 4'd1) && (d_s1 <= 4'd11);
        rnd   = s1_ok ? (23'd1 << (d_s1 - 4'd1)) : '0;
        y_d   = y_q;
        if (ld2) y_d = s1_ok ? 12'((prod_q + rnd) >> d_s1) : 12'd0;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            prod_q <= '0;
            y_q    <= '0;
        end else begin
            prod_q <= prod_d;
            y_q    <= y_d;
        end
    end

    assign y_out = y_q;

`ifdef DECOMPRESS_RANGE_CHK_EN
    assign hi_err = d_ok && |(x_in & ~mask);
`endif
endmodule

module kyber_decompress_stream #(
    parameter int LANES  = 4,
    parameter int Q      = 3329,
    parameter int NCOEFF = 256
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    kyber_decompress_stream_if.slave bus
);
    localparam int STAGES = 2;
    localparam int BEATS  = NCOEFF / LANES;
    localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic                    en;
    logic                    accept;
    logic [STAGES:1]         vld_pipe_d, vld_pipe_q;
    logic [CW-1:0]           cnt_d, cnt_q;
    logic                    last1_d, last1_q;
    logic                    last2_d, last2_q;
    logic [3:0]              d1_d, d1_q;
    logic [LANES-1:0][10:0]  x_in;
    logic [LANES-1:0][11:0]  y;

    assign x_in   = bus.i_coeff;
    assign en     = !vld_pipe_q[STAGES] | bus.i_ready;
    assign accept = bus.i_valid & en;

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        cnt_d      = cnt_q;
        last1_d    = last1_q;
        last2_d    = last2_q;
        d1_d       = d1_q;
        // Whole pipe advances together, so bubbles move with the data.
        if (en) begin
            vld_pipe_d = {vld_pipe_q[STAGES-1:1], bus.i_valid};
            last1_d    = accept && (cnt_q == CW'(BEATS - 1));
            last2_d    = vld_pipe_q[1] & last1_q;
        end
        if (accept) begin
            d1_d  = bus.i_d;
            cnt_d = (cnt_q == CW'(BEATS - 1)) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            vld_pipe_q <= '0;
            cnt_q      <= '0;
            last1_q    <= 1'b0;
            last2_q    <= 1'b0;
            d1_q       <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            cnt_q      <= cnt_d;
            last1_q    <= last1_d;
            last2_q    <= last2_d;
            d1_q       <= d1_d;
        end
    end

`ifdef DECOMPRESS_RANGE_CHK_EN
    logic [LANES-1:0] hi_err;
    logic             err_d, err_q;
`endif

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        kyber_decompress_lane #(.Q(Q)) u_lane (
            .i_clk  (i_clk),
            .i_rstn (i_rstn),
            .ld1    (accept),
            .ld2    (en & vld_pipe_q[1]),
            .d_in   (bus.i_d),
            .d_s1   (d1_q),
            .x_in   (x_in[k]),
            .y_out  (y[k])
`ifdef DECOMPRESS_RANGE_CHK_EN
            ,
            .hi_err (hi_err[k])
`endif
        );
    end

`ifdef DECOMPRESS_RANGE_CHK_EN
    always_comb begin
        err_d = err_q;
        if (accept && ((bus.i_d == 4'd0) || (bus.i_d > 4'd11) || (|hi_err))) err_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    assign bus.o_range_err = err_q;
`else
    assign bus.o_range_err = 1'b0;
`endif

    assign bus.o_ready = en;
    assign bus.o_valid = vld_pipe_q[STAGES];
    assign bus.o_coeff = y;
    assign bus.o_last  = last2_q;
endmodule
